// File: rtl/ifft_pkg.sv
// ifft_pkg: shared widths, FSM states, twiddle constant and butterfly scheduling helpers for ifft_8pt.
package ifft_pkg;
    localparam int N_DEF = 4;
    localparam int GUARD_DEF = 2;
    localparam int DW_DEF = 2**N_DEF;
    localparam int IW_DEF = DW_DEF + GUARD_DEF;
    localparam int C_Q30 = 759250125;

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] m;
    } bf_t;

    // cos(pi/4) in Q1.(dw-2), derived from a Q30 master constant
    function automatic int c_q(input int dw);
        return C_Q30 >>> (32 - dw);
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // k = {stage, pair}: returns in-place addresses a, b = a+span and twiddle index m
    function automatic bf_t bf_map(input logic [3:0] k);
        logic [1:0] s, j;
        logic [2:0] span, a;
        s = k[3:2];
        span = 3'd1 << s;
        j = k[1:0] & 2'(span - 3'd1);
        a = ((3'(k[1:0]) >> s) << (s + 2'd1)) | 3'(j);
        return '{a: a, b: a + span, m: 2'(j << (2'd2 - s))};
    endfunction
endpackage

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: combinational radix-2 IFFT butterfly with W8^(+m) twiddle and 1/2 scaling.
module ifft_butterfly
    import ifft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    input  logic [1:0]           m,
    output logic signed [IW-1:0] ya_re,
    output logic signed [IW-1:0] ya_im,
    output logic signed [IW-1:0] yb_re,
    output logic signed [IW-1:0] yb_im
);
    localparam int PW = IW + DW + 2;
    localparam int F = DW - 2;
    localparam logic signed [PW-1:0] C = PW'(c_q(DW));
    logic signed [PW-1:0] pp, pm, pn;
    logic signed [IW-1:0] t_re, t_im;
    logic signed [IW:0] sa_re, sa_im, sb_re, sb_im;

    always_comb begin
        pp = (PW'(b_re) + PW'(b_im)) * C;
        pm = (PW'(b_re) - PW'(b_im)) * C;
        pn = -pp;
        t_re = m == 2'd0 ? b_re : m == 2'd1 ? IW'(pm >>> F) : m == 2'd2 ? -b_im : IW'(pn >>> F);
        t_im = m == 2'd0 ? b_im : m == 2'd1 ? IW'(pp >>> F) : m == 2'd2 ? b_re : IW'(pm >>> F);
        sa_re = (IW+1)'(a_re) + (IW+1)'(t_re);
        sa_im = (IW+1)'(a_im) + (IW+1)'(t_im);
        sb_re = (IW+1)'(a_re) - (IW+1)'(t_re);
        sb_im = (IW+1)'(a_im) - (IW+1)'(t_im);
        ya_re = IW'(sa_re >>> 1);
        ya_im = IW'(sa_im >>> 1);
        yb_re = IW'(sb_re >>> 1);
        yb_im = IW'(sb_im >>> 1);
    end
endmodule

// File: rtl/ifft_8pt.sv
// ifft_8pt: serial 8-point radix-2 DIT inverse FFT with one shared butterfly.
// Loads 8 bins in bit-reversed order, runs 12 in-place butterflies, streams 8 saturated real samples.
module ifft_8pt
    import ifft_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2**N-1:0] in_re,
    input  logic [2**N-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2**N-1:0] out_data,
    output logic [2:0]    out_idx,
    output logic          busy
);
    localparam int DW = 2**N;
    localparam int IW = DW + GUARD;
    localparam logic signed [IW-1:0] SMAX = {{(GUARD+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [IW-1:0] SMIN = {{(GUARD+1){1'b1}}, {(DW-1){1'b0}}};

    state_t state_q, state_d;
    logic [3:0] cnt;
    logic signed [IW-1:0] re_q [8];
    logic signed [IW-1:0] im_q [8];
    logic signed [IW-1:0] ya_re, ya_im, yb_re, yb_im, nxt;
    logic [DW-1:0] sat;
    logic [2:0] nidx;
    logic acc, fire;
    bf_t bf;

    ifft_butterfly #(.DW(DW), .IW(IW)) u_bf (
        .a_re(re_q[bf.a]), .a_im(im_q[bf.a]),
        .b_re(re_q[bf.b]), .b_im(im_q[bf.b]),
        .m(bf.m),
        .ya_re(ya_re), .ya_im(ya_im), .yb_re(yb_re), .yb_im(yb_im)
    );

    always_comb begin
        acc = in_valid && in_ready;
        fire = state_q == OUT && out_valid && out_ready;
        bf = bf_map(cnt);
        nidx = out_valid ? out_idx + 3'd1 : 3'd0;
        nxt = re_q[nidx];
        sat = nxt > SMAX ? {1'b0, {(DW-1){1'b1}}} : nxt < SMIN ? {1'b1, {(DW-1){1'b0}}} : nxt[DW-1:0];
        state_d = (state_q == LOAD && acc && cnt == 4'd7) ? COMPUTE :
                  (state_q == COMPUTE && cnt == 4'd11) ? OUT :
                  (fire && out_idx == 3'd7) ? LOAD : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt <= '0;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_data <= '0;
            out_idx <= '0;
        end else begin
            state_q <= state_d;
            in_ready <= state_d == LOAD;
            cnt <= state_d != state_q ? 4'd0 : (acc || state_q == COMPUTE) ? cnt + 4'd1 : cnt;
            // output register refills on OUT entry and on every accepted sample
            if (state_q == OUT && (!out_valid || out_ready)) begin
                out_valid <= !(out_valid && out_idx == 3'd7);
                out_idx <= nidx;
                out_data <= sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            re_q[bitrev3(cnt[2:0])] <= IW'($signed(in_re));
            im_q[bitrev3(cnt[2:0])] <= IW'($signed(in_im));
        end else if (state_q == COMPUTE) begin
            re_q[bf.a] <= ya_re;
            im_q[bf.a] <= ya_im;
            re_q[bf.b] <= yb_re;
            im_q[bf.b] <= yb_im;
        end
    end

    assign busy = state_q != LOAD;
endmodule

// File: tb/tb_ifft_8pt.sv
// tb_ifft_8pt: table-driven directed checks of ifft_8pt plus backpressure and mid-frame reset sequences.
module tb_ifft_8pt;
    typedef logic [0:7][15:0] w8_t;
    typedef struct packed {
        w8_t re;
        w8_t ex;
        logic [3:0] tol;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic in_ready, out_valid, busy;
    logic [15:0] out_data;
    logic [2:0] out_idx;
    int checks = 0;
    int errors = 0;
    vec_t vecs [5];

    ifft_8pt #(.N(4), .GUARD(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic w8_t w8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a0), 16'(a1), 16'(a2), 16'(a3), 16'(a4), 16'(a5), 16'(a6), 16'(a7)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_idx"}, int'(out_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // leaves in_valid high with junk data so COMPUTE/OUT must ignore it
    task automatic send_frame(input w8_t re);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = re[k];
            in_im = '0;
            chk($sformatf("in_ready_load[%0d]", k), int'(in_ready), 1);
            @(posedge clk);
        end
        #1;
        in_re = 16'h5a5a;
        in_im = 16'h1234;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        in_valid = 1'b0;
    endtask

    task automatic collect(input w8_t ex, input int tol, input bit bp);
        int got = 0;
        int c = 0;
        bit stalled = 0;
        int pd = 0;
        int pi = 0;
        while (got < 8 && c < 200) begin
            out_ready = bp ? (c % 3 == 0) : 1'b1;
            if (stalled && out_valid) begin
                chk("hold_data", int'(out_data), pd);
                chk("hold_idx", int'(out_idx), pi);
            end
            if (out_valid) begin
                chk("in_ready_low", int'(in_ready), 0);
                if (out_ready) begin
                    chk($sformatf("idx[%0d]", got), int'(out_idx), got);
                    chk_tol($sformatf("data[%0d]", got), int'($signed(out_data)), int'($signed(ex[got])), tol);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = int'(out_data);
                    pi = int'(out_idx);
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        if (got < 8) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got %0d samples expected 8", got);
        end
        chk("valid_after_frame", int'(out_valid), 0);
        chk("ready_after_frame", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit bp);
        int lat;
        send_frame(v.re);
        wait_out(lat);
        chk("latency", lat, 13);
        collect(v.ex, int'(v.tol), bp);
    endtask

    initial begin
        int quiet;
        vecs[0] = '{re: w8(800, 0, 0, 0, 0, 0, 0, 0), ex: w8(100, 100, 100, 100, 100, 100, 100, 100), tol: 4'd0};
        vecs[1] = '{re: w8(0, 0, 0, 0, 800, 0, 0, 0), ex: w8(100, -100, 100, -100, 100, -100, 100, -100), tol: 4'd0};
        vecs[2] = '{re: w8(0, 4000, 0, 0, 0, 0, 0, 4000), ex: w8(1000, 707, 0, -707, -1000, -707, 0, 707), tol: 4'd2};
        vecs[3] = '{re: w8(32767, 0, 0, 0, 32767, 0, 0, 0), ex: w8(8191, 0, 8191, 0, 8191, 0, 8191, 0), tol: 4'd0};
        vecs[4] = '{re: w8(32767, 0, 32767, 0, 32767, 0, 32767, 0), ex: w8(16383, 0, 0, 0, 16383, 0, 0, 0), tol: 4'd0};

        #2 rst = 1'b1;
        #20;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        run_vec(vecs[0], 1'b1);

        // abort a frame during the sixth COMPUTE cycle
        send_frame(vecs[1].re);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
        end
        chk("no_output_after_abort", quiet, 1);
        @(posedge clk);
        #1;
        run_vec(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
